// File: rtl/arch_pkg.sv
// Shared types for the layer phase sequencer: controller states and index-width helper.
package arch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        BWD,
        GAP,
        DONE
    } state_t;

    // Layer index width, never narrower than one bit so LAYERS=1 still has an index.
    function automatic int layer_idx_w(input int layers);
        return (layers > 1) ? $clog2(layers) : 1;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one layer phase; expire flags the last cycle of the phase.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] value,
    output logic             expire
);

    logic [CNT_W-1:0] value_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_reg <= '0;
        end else if (load) begin
            value_reg <= load_val;
        end else if (value_reg != '0) begin
            value_reg <= value_reg - 1'b1;
        end
    end

    assign value  = value_reg;
    assign expire = (value_reg == CNT_W'(1));

endmodule

// File: rtl/arch_phase_seq.sv
// Forward/backward phase sequencer over LAYERS layers for training and validation runs.
// Define ARCH_PHASE_GAP_EN to insert a one-cycle settle gap between consecutive phases.
module arch_phase_seq
    import arch_pkg::*;
#(
    parameter int LAYERS  = 2,
    parameter int FP_CYC  = 4,
    parameter int BP_CYC  = 4,
    parameter int CNT_W   = 8,
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tr,
    input  logic               vl,
    input  logic [EPOCH_W-1:0] epochs,
    output logic [LAYERS-1:0]  fp,
    output logic [LAYERS-1:0]  bp,
    output logic               busy,
    output logic               done,
    output logic [EPOCH_W-1:0] epoch_cnt,
    output logic               val_mode
);

    localparam int               LAYER_IDX_W = layer_idx_w(LAYERS);
    localparam logic [LAYER_IDX_W-1:0] LAST_IDX = LAYER_IDX_W'(LAYERS - 1);
    localparam logic [CNT_W-1:0] FP_LD = CNT_W'(FP_CYC);
    localparam logic [CNT_W-1:0] BP_LD = CNT_W'(BP_CYC);

    state_t                   state_reg, state_next;
    logic [LAYER_IDX_W-1:0]   idx_reg, idx_next;
    logic [EPOCH_W-1:0]       epochs_reg, epochs_next;
    logic [EPOCH_W-1:0]       epoch_cnt_reg, epoch_cnt_next;
    logic [EPOCH_W-1:0]       epoch_inc;
    logic                     val_mode_reg, val_mode_next;
    logic [LAYERS-1:0]        fp_reg, fp_next, bp_reg, bp_next;
    logic                     busy_reg, busy_next, done_reg, done_next;
`ifdef ARCH_PHASE_GAP_EN
    state_t                   tgt_reg, tgt_next;
`endif

    logic                     adv;
    state_t                   adv_state;
    logic [LAYER_IDX_W-1:0]   adv_idx;
    logic                     tmr_load;
    logic [CNT_W-1:0]         tmr_val;
    logic [CNT_W-1:0]         tmr_value;
    logic                     tmr_expire;
    logic                     unused_tmr;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .value    (tmr_value),
        .expire   (tmr_expire)
    );

    assign unused_tmr = ^tmr_value;
    assign epoch_inc  = epoch_cnt_reg + 1'b1;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        epochs_next    = epochs_reg;
        epoch_cnt_next = epoch_cnt_reg;
        val_mode_next  = val_mode_reg;
        tmr_load       = 1'b0;
        tmr_val        = FP_LD;
        adv            = 1'b0;
        adv_state      = IDLE;
        adv_idx        = idx_reg;
`ifdef ARCH_PHASE_GAP_EN
        tgt_next       = tgt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (tr) begin
                    epochs_next    = epochs;
                    epoch_cnt_next = '0;
                    val_mode_next  = 1'b0;
                    idx_next       = '0;
                    if (epochs == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = FWD;
                        tmr_load   = 1'b1;
                    end
                end else if (vl) begin
                    epoch_cnt_next = '0;
                    val_mode_next  = 1'b1;
                    idx_next       = '0;
                    state_next     = FWD;
                    tmr_load       = 1'b1;
                end
            end
            FWD: begin
                if (tmr_expire) begin
                    adv = 1'b1;
                    if (idx_reg == LAST_IDX) begin
                        adv_state = val_mode_reg ? DONE : BWD;
                    end else begin
                        adv_state = FWD;
                        adv_idx   = idx_reg + 1'b1;
                    end
                end
            end
            BWD: begin
                if (tmr_expire) begin
                    adv = 1'b1;
                    if (idx_reg == '0) begin
                        epoch_cnt_next = epoch_inc;
                        adv_state      = (epoch_inc == epochs_reg) ? DONE : FWD;
                        adv_idx        = '0;
                    end else begin
                        adv_state = BWD;
                        adv_idx   = idx_reg - 1'b1;
                    end
                end
            end
`ifdef ARCH_PHASE_GAP_EN
            GAP: begin
                state_next = tgt_reg;
                tmr_load   = 1'b1;
                tmr_val    = (tgt_reg == BWD) ? BP_LD : FP_LD;
            end
`endif
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // Phase hand-off: the final phase of a run always goes straight to DONE.
        if (adv) begin
            idx_next = adv_idx;
            if (adv_state == DONE) begin
                state_next = DONE;
            end else begin
`ifdef ARCH_PHASE_GAP_EN
                state_next = GAP;
                tgt_next   = adv_state;
`else
                state_next = adv_state;
                tmr_load   = 1'b1;
                tmr_val    = (adv_state == BWD) ? BP_LD : FP_LD;
`endif
            end
        end

        fp_next   = (state_next == FWD) ? (LAYERS'(1) << idx_next) : '0;
        bp_next   = (state_next == BWD) ? (LAYERS'(1) << idx_next) : '0;
        busy_next = (state_next == FWD) || (state_next == BWD) || (state_next == GAP);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            epochs_reg    <= '0;
            epoch_cnt_reg <= '0;
            val_mode_reg  <= 1'b0;
            fp_reg        <= '0;
            bp_reg        <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef ARCH_PHASE_GAP_EN
            tgt_reg       <= IDLE;
`endif
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            epochs_reg    <= epochs_next;
            epoch_cnt_reg <= epoch_cnt_next;
            val_mode_reg  <= val_mode_next;
            fp_reg        <= fp_next;
            bp_reg        <= bp_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
`ifdef ARCH_PHASE_GAP_EN
            tgt_reg       <= tgt_next;
`endif
        end
    end

    assign fp        = fp_reg;
    assign bp        = bp_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign epoch_cnt = epoch_cnt_reg;
    assign val_mode  = val_mode_reg;

endmodule

// File: tb/tb_arch_phase_seq.sv
// Scoreboard bench for arch_phase_seq (LAYERS=2, FP_CYC=3, BP_CYC=2); honours ARCH_PHASE_GAP_EN.
module tb_arch_phase_seq;

    localparam int L  = 2;
    localparam int FC = 3;
    localparam int BC = 2;
`ifdef ARCH_PHASE_GAP_EN
    localparam bit GAP_ON = 1'b1;
`else
    localparam bit GAP_ON = 1'b0;
`endif

    typedef struct packed {
        logic [L-1:0] fp;
        logic [L-1:0] bp;
        logic         busy;
        logic         done;
        logic [7:0]   ec;
        logic         vm;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         tr = 1'b0;
    logic         vl = 1'b0;
    logic [7:0]   epochs = '0;
    logic [L-1:0] fp, bp;
    logic         busy, done, val_mode;
    logic [7:0]   epoch_cnt;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    arch_phase_seq #(
        .LAYERS(L), .FP_CYC(FC), .BP_CYC(BC), .CNT_W(8), .EPOCH_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tr        (tr),
        .vl        (vl),
        .epochs    (epochs),
        .fp        (fp),
        .bp        (bp),
        .busy      (busy),
        .done      (done),
        .epoch_cnt (epoch_cnt),
        .val_mode  (val_mode)
    );

    always #5 clk = ~clk;

    task automatic push_e(input logic [L-1:0] f, input logic [L-1:0] b,
                          input logic bz, input logic dn, input int ec, input bit vm);
        exp_t x;
        x.fp = f; x.bp = b; x.busy = bz; x.done = dn; x.ec = 8'(ec); x.vm = vm;
        sb.push_back(x);
    endtask

    // Expected per-cycle trace of a whole run, starting the cycle after the start edge.
    task automatic push_run(input int ep, input bit val);
        int  ec = 0;
        bit  first = 1'b1;
        int  ne = val ? 1 : ep;
        for (int e = 0; e < ne; e++) begin
            for (int l = 0; l < L; l++) begin
                if (!first && GAP_ON) push_e('0, '0, 1'b1, 1'b0, ec, val);
                first = 1'b0;
                for (int c = 0; c < FC; c++) push_e(L'(1) << l, '0, 1'b1, 1'b0, ec, val);
            end
            if (!val) begin
                for (int l = L - 1; l >= 0; l--) begin
                    if (GAP_ON) push_e('0, '0, 1'b1, 1'b0, ec, val);
                    for (int c = 0; c < BC; c++) push_e('0, L'(1) << l, 1'b1, 1'b0, ec, val);
                end
                ec++;
            end
        end
        push_e('0, '0, 1'b0, 1'b1, ec, val);
    endtask

    task automatic start(input bit t, input bit v, input int ep);
        @(negedge clk);
        tr = t; vl = v; epochs = 8'(ep);
        @(posedge clk);
        #1;
    endtask

    // Pops one expectation per cycle; tr is re-driven at cycle rp and held high below hold.
    task automatic drain(input string name, input int rp, input int hold, input int max_n);
        exp_t x;
        int   c = 1;
        while (sb.size() > 0 && (max_n < 0 || c <= max_n)) begin
            x = sb.pop_front();
            checks++;
            if ({fp, bp, busy, done, epoch_cnt, val_mode} !== x) begin
                errors++;
                $display("FAIL %s cycle %0d: fp=%b bp=%b busy=%b done=%b ec=%0d vm=%b, want fp=%b bp=%b busy=%b done=%b ec=%0d vm=%b",
                         name, c, fp, bp, busy, done, epoch_cnt, val_mode,
                         x.fp, x.bp, x.busy, x.done, x.ec, x.vm);
            end else begin
                $display("ok %s cycle %0d: fp=%b bp=%b busy=%b done=%b ec=%0d vm=%b",
                         name, c, fp, bp, busy, done, epoch_cnt, val_mode);
            end
            tr = (c == rp) || (c < hold);
            vl = 1'b0;
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic check_idle(input string name);
        checks++;
        if ({fp, bp, busy, done} !== '0) begin
            errors++;
            $display("FAIL %s: fp=%b bp=%b busy=%b done=%b, want all 0", name, fp, bp, busy, done);
        end else begin
            $display("ok %s: idle outputs all 0", name);
        end
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({fp, bp, busy, done, epoch_cnt, val_mode} !== '0) begin
            errors++;
            $display("FAIL reset: fp=%b bp=%b busy=%b done=%b ec=%0d vm=%b, want all 0",
                     fp, bp, busy, done, epoch_cnt, val_mode);
        end else begin
            $display("ok reset: all outputs 0");
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset_release");
    endtask

    task automatic test_train_one();
        push_run(1, 1'b0);
        start(1'b1, 1'b0, 1);
        drain("train_ep1", 0, 0, -1);
        check_idle("train_ep1_after");
    endtask

    task automatic test_validate();
        push_run(1, 1'b1);
        start(1'b0, 1'b1, 5);
        drain("validate", 0, 0, -1);
        check_idle("validate_after");
    endtask

    task automatic test_multi_epoch();
        push_run(3, 1'b0);
        start(1'b1, 1'b0, 3);
        drain("train_ep3_repulse", 15, 0, -1);
        check_idle("train_ep3_after");
    endtask

    task automatic test_priority_and_zero();
        push_run(1, 1'b0);
        start(1'b1, 1'b1, 1);
        drain("tr_vl_both", 0, 0, -1);
        push_run(0, 1'b0);
        start(1'b1, 1'b0, 0);
        drain("epochs_zero", 0, 0, -1);
        check_idle("epochs_zero_after");
    endtask

    task automatic test_abort();
        push_run(1, 1'b0);
        start(1'b1, 1'b0, 1);
        drain("abort_pre", 0, 0, 4);
        sb.delete();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fp, bp, busy, done, epoch_cnt, val_mode} !== '0) begin
            errors++;
            $display("FAIL abort_async: fp=%b bp=%b busy=%b done=%b ec=%0d vm=%b, want all 0",
                     fp, bp, busy, done, epoch_cnt, val_mode);
        end else begin
            $display("ok abort_async: outputs cleared without clock");
        end
        repeat (2) @(posedge clk);
        #1;
        check_idle("abort_held");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_idle("abort_released");
        push_run(1, 1'b0);
        start(1'b1, 1'b0, 1);
        drain("abort_restart", 0, 0, -1);
    endtask

    // tr held high across DONE restarts a second run once IDLE is re-entered.
    task automatic test_back_to_back();
        int run_len;
        push_run(1, 1'b0);
        run_len = sb.size();
        push_e('0, '0, 1'b0, 1'b0, 1, 1'b0);
        push_run(1, 1'b0);
        start(1'b1, 1'b0, 1);
        drain("back_to_back", 0, run_len + 3, -1);
        check_idle("back_to_back_after");
    endtask

    initial begin
        test_reset();
        test_train_one();
        test_validate();
        test_multi_epoch();
        test_priority_and_zero();
        test_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/arch_phase_seq.md
Name: arch_phase_seq

Overview:
Parametrised successor to the fixed four-phase architecture controller. It sequences forward and backward phase enables over a configurable number of layers, with programmable cycle counts per phase. It runs multi-epoch training (tr) or a single forward-only validation pass (vl), and reports progress with busy, done and an epoch counter. It sits beside the neuron layers and drives their FP/BP inputs: layer k neurons take FP=fp[k] and BP=bp[k].

Parameters:
LAYERS, 2, number of layers sequenced (>=1)
FP_CYC, 4, cycles each layer's forward enable is held (>=1)
BP_CYC, 4, cycles each layer's backward enable is held (>=1)
CNT_W, 8, width of the internal phase-cycle counter (must hold max(FP_CYC,BP_CYC))
EPOCH_W, 8, width of epochs and epoch_cnt

Ports:
clk  in  1  system clock, all state on the rising edge
rst_n  in  1  asynchronous active-low reset
tr  in  1  training start request, level sampled only in IDLE
vl  in  1  validation start request, level sampled only in IDLE
epochs  in  EPOCH_W  number of training epochs, captured at start
fp  out  LAYERS  one-hot forward-phase enable, bit k = layer k
bp  out  LAYERS  one-hot backward-phase enable, bit k = layer k
busy  out  1  high in FWD/BWD (and GAP)
done  out  1  single-cycle completion pulse
epoch_cnt  out  EPOCH_W  completed epochs in current/last run
val_mode  out  1  high while the current run is a validation run

Behaviour:
- Reset (async, rst_n=0): state=IDLE. fp=0, bp=0, busy=0, done=0, epoch_cnt=0, val_mode=0. Internal layer index and counters are cleared.
- Reset mid-run aborts immediately with no done pulse.
- States: IDLE, FWD, BWD, DONE (plus GAP with the optional feature).
- IDLE, tr=1 at edge k:
  - epochs is captured; epoch_cnt and val_mode are cleared; layer index=0.
  - FWD is entered, so fp[0]=1 from cycle k+1.
  - If captured epochs==0, DONE is entered instead.
- IDLE, vl=1 with tr=0: val_mode=1, FWD is entered with layer 0.
- tr and vl both high: tr wins.
- tr/vl in any non-IDLE state: ignored. Requests are level-sensitive, so a level still high when IDLE is re-entered starts a new run.
- FWD: fp[idx] is held for exactly FP_CYC cycles. Then idx increments.
  - After layer LAYERS-1 in a training run: enter BWD with idx=LAYERS-1.
  - After layer LAYERS-1 in a validation run: enter DONE.
- BWD: bp[idx] is held for exactly BP_CYC cycles, with idx descending.
  - After layer 0, epoch_cnt increments.
  - If epoch_cnt (new value) == captured epochs: enter DONE.
  - Otherwise: enter FWD with idx=0 (no dead cycle).
- DONE: lasts one cycle. done=1, busy=0, fp=bp=0. Next state is IDLE. The tr/vl inputs are not sampled in DONE.
- epoch_cnt and val_mode hold their final values in IDLE until the next start.
- Output rules:
  - At most one bit of fp|bp is high in any cycle.
  - Outputs are registered, with no combinational path from tr/vl.
- Cycle budget with no gaps:
  - Training: epochs*LAYERS*(FP_CYC+BP_CYC) busy cycles, then the done cycle.
  - Validation: LAYERS*FP_CYC busy cycles, then the done cycle.

Optional Feature:
ARCH_PHASE_GAP_EN: when defined, a one-cycle GAP state separates every pair of consecutive layer phases in a run, including across epoch boundaries. During GAP, fp=bp=0 and busy=1; it lets neuron registers settle.
- No GAP is inserted after the final phase of a run; the run goes straight to DONE.
- When undefined, GAP does not exist and phases are back-to-back.

Decomposition:
- Shared package arch_pkg holds:
  - state enum typedef (IDLE, FWD, BWD, GAP, DONE)
  - LAYER_IDX_W = $clog2(LAYERS) (min 1)
- One sub-module, phase_timer: a loadable CNT_W down-counter with load, value and expire outputs. It is instantiated once and reloaded with FP_CYC or BP_CYC at each phase entry.

Test Plan:
All scenarios use LAYERS=2, FP_CYC=3, BP_CYC=2; tr or vl is sampled at edge 0.
1. tr pulse, epochs=1 -> fp[0] cycles 1-3, fp[1] 4-6, bp[1] 7-8, bp[0] 9-10, done=1 cycle 11, epoch_cnt=1, busy low at 11.
2. vl pulse -> fp[0] 1-3, fp[1] 4-6, bp never high, done at 7, val_mode=1, epoch_cnt=0.
3. tr pulse, epochs=3 -> three identical 10-cycle epochs, epoch_cnt 1/2/3 after cycles 10/20/30, done at 31. A tr re-pulse at cycle 15 is ignored.
4. tr=vl=1 together, epochs=1 -> training sequence as in scenario 1, val_mode=0. Separately, epochs=0 -> done at cycle 1, no fp/bp.
5. rst_n low at cycle 5 of scenario 1 -> all outputs 0 asynchronously, state IDLE, no done pulse; tr after release restarts from fp[0].
6. ARCH_PHASE_GAP_EN defined, epochs=1 -> fp[0] 1-3, gap 4, fp[1] 5-7, gap 8, bp[1] 9-10, gap 11, bp[0] 12-13, done 14.
